// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program counter and fetch controller that issues instruction-memory words downstream over valid/ready
`timescale 1ns/1ps
module fetch_sequencer #(
  parameter int ADDR_W   = 3,
  parameter int PROG_LEN = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] counter,
  input  logic [31:0]       instr_in,
  output logic [31:0]       instr_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              busy,
  output logic              done,
  output logic [7:0]        issued_count
);
  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, DONE} state_t;
  localparam logic [ADDR_W:0]   prog_len_w = (ADDR_W+1)'(PROG_LEN);
  localparam logic [ADDR_W-1:0] last_idx   = ADDR_W'(PROG_LEN - 1);
  state_t state;
  assign busy = state == FETCH || state == ISSUE;
  assign done = state == DONE;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      counter      <= '0;
      instr_out    <= '0;
      pc_out       <= '0;
      instr_valid  <= 1'b0;
      issued_count <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          state        <= FETCH;
          counter      <= '0;
          issued_count <= '0;
        end
        FETCH: begin
          instr_out   <= instr_in;
          pc_out      <= counter;
          instr_valid <= 1'b1;
          state       <= ISSUE;
        end
        ISSUE: if (instr_ready) begin
          issued_count <= issued_count + 8'd1;
          instr_valid  <= 1'b0;
          if (redirect_valid && {1'b0, redirect_target} < prog_len_w) begin
            counter <= redirect_target;
            state   <= FETCH;
          end else if (redirect_valid || pc_out == last_idx) begin
            state <= DONE;
          end else begin
            counter <= pc_out + 1'b1;
            state   <= FETCH;
          end
        end
      endcase
    end
  end
endmodule
